// File: rtl/arm_pkg.sv
// Shared definitions for the ARM core memory path: SRAM controller FSM states,
// SRAM data width and the byte-address-to-word-index helper.
package arm_pkg;

    localparam int unsigned SRAM_DW = 16;

    typedef enum logic [1:0] {
        StIdle,
        StLow,
        StHigh,
        StDone
    } sram_state_e;

    // Unsigned 32-bit offset from the SRAM base; addresses below the base wrap.
    function automatic logic [29:0] sram_word_index(input logic [31:0] addr,
                                                    input logic [31:0] base);
        logic [31:0] off;
        off = addr - base;
        return 30'(off >> 2);
    endfunction

endpackage

// File: rtl/sram_controller.sv
// Mem-stage bridge to a 16-bit asynchronous SRAM: each 32-bit load/store is split into
// a low and a high halfword phase while ready stalls the pipeline.
module sram_controller
    import arm_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE    = 32'd1024,
    parameter int unsigned SRAM_AW      = 18,
    parameter int unsigned PHASE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic [31:0]          address,
    input  logic [31:0]          write_data,
    output logic [31:0]          read_data,
    output logic                 ready,
    inout  wire  [SRAM_DW-1:0]   SRAM_DQ,
    output logic [SRAM_AW-1:0]   SRAM_ADDR,
    output logic                 SRAM_WE_N,
    output logic                 SRAM_OE_N,
    output logic                 SRAM_CE_N,
    output logic                 SRAM_UB_N,
    output logic                 SRAM_LB_N
);

    localparam int unsigned CNT_W = $clog2(PHASE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PHASE_CYCLES - 1);

    sram_state_e          state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 op_write_q;
    logic [29:0]          idx_q;
    logic [SRAM_DW-1:0]   wdata_hi_q;
    logic [SRAM_DW-1:0]   dq_out_q;
    logic                 dq_oe_q;

    logic [29:0]          idx_in;
    logic [30:0]          hw_lo_addr;
    logic [30:0]          hw_hi_addr;
    logic                 last_phase;
    logic                 request;

    always_comb begin
        idx_in     = sram_word_index(address, ADDR_BASE);
        hw_lo_addr = {idx_in, 1'b0};
        hw_hi_addr = {idx_q, 1'b1};
        last_phase = (cnt_q == LAST_CNT);
        request    = rd_en | wr_en;
    end

    assign ready   = (state_q == StDone) || ((state_q == StIdle) && !request);
    assign SRAM_DQ = dq_oe_q ? dq_out_q : {SRAM_DW{1'bz}};

    // Strobes, address and bus enable are registered alongside the state so they are
    // valid for the whole of each LOW/HIGH cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            op_write_q <= 1'b0;
            idx_q      <= '0;
            wdata_hi_q <= '0;
            dq_out_q   <= '0;
            dq_oe_q    <= 1'b0;
            read_data  <= '0;
            SRAM_ADDR  <= '0;
            SRAM_WE_N  <= 1'b1;
            SRAM_OE_N  <= 1'b1;
            SRAM_CE_N  <= 1'b1;
            SRAM_UB_N  <= 1'b1;
            SRAM_LB_N  <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (request) begin
                        state_q    <= StLow;
                        cnt_q      <= '0;
                        op_write_q <= wr_en;
                        idx_q      <= idx_in;
                        wdata_hi_q <= write_data[31:16];
                        dq_out_q   <= write_data[15:0];
                        dq_oe_q    <= wr_en;
                        SRAM_ADDR  <= SRAM_AW'(hw_lo_addr);
                        SRAM_WE_N  <= ~wr_en;
                        SRAM_OE_N  <= wr_en;
                        SRAM_CE_N  <= 1'b0;
                        SRAM_UB_N  <= 1'b0;
                        SRAM_LB_N  <= 1'b0;
                    end
                end
                StLow: begin
                    if (last_phase) begin
                        if (!op_write_q) begin
                            read_data[15:0] <= SRAM_DQ;
                        end
                        state_q   <= StHigh;
                        cnt_q     <= '0;
                        dq_out_q  <= wdata_hi_q;
                        SRAM_ADDR <= SRAM_AW'(hw_hi_addr);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StHigh: begin
                    if (last_phase) begin
                        if (!op_write_q) begin
                            read_data[31:16] <= SRAM_DQ;
                        end
                        state_q   <= StDone;
                        cnt_q     <= '0;
                        dq_oe_q   <= 1'b0;
                        SRAM_WE_N <= 1'b1;
                        SRAM_OE_N <= 1'b1;
                        SRAM_CE_N <= 1'b1;
                        SRAM_UB_N <= 1'b1;
                        SRAM_LB_N <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 1024: byte address mapped to SRAM word 0.
REQ-002 SHALL have parameter SRAM_AW, default 18: SRAM address width.
REQ-003 SHALL have parameter PHASE_CYCLES, default 2, legal range >=1: cycles per 16-bit halfword access.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port wr_en  input  1  store request from mem stage.
REQ-007 SHALL have port rd_en  input  1  load request from mem stage.
REQ-008 SHALL have port address  input  32  byte address (ALU result).
REQ-009 SHALL have port write_data  input  32  store data (val_Rm).
REQ-010 SHALL have port read_data  output  32  load result, registered.
REQ-011 SHALL have port ready  output  1  low = pipeline freeze.
REQ-012 SHALL have port SRAM_DQ  inout  16  SRAM data bus.
REQ-013 SHALL have port SRAM_ADDR  output  SRAM_AW  SRAM halfword address.
REQ-014 SHALL have ports SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  output  1 each  active-low SRAM strobes.

Function
REQ-015 SHALL implement FSM states IDLE, LOW, HIGH, DONE.
REQ-016 IDLE with rd_en|wr_en=1: SHALL capture address, write_data, and op (write if wr_en=1, including rd_en=wr_en=1), then go to LOW.
REQ-017 LOW SHALL last PHASE_CYCLES cycles, then go to HIGH. HIGH SHALL last PHASE_CYCLES cycles, then go to DONE. DONE SHALL last 1 cycle, then go to IDLE.
REQ-018 ready SHALL be combinational: 1 in IDLE with rd_en=wr_en=0; 0 in IDLE with a request; 0 in LOW and HIGH; 1 in DONE.
REQ-019 Total freeze for one request SHALL be 2*PHASE_CYCLES+1 cycles, with ready=1 in the following (DONE) cycle.
REQ-020 Word index SHALL be (captured address - ADDR_BASE)[31:2], unsigned 32-bit, so addresses below ADDR_BASE wrap modulo 2^32.
REQ-021 SRAM_ADDR SHALL be {index,1'b0} in LOW and {index,1'b1} in HIGH, truncated to SRAM_AW bits.
REQ-022 LOW SHALL transfer bits [15:0]; HIGH SHALL transfer bits [31:16].
REQ-023 In LOW/HIGH, SRAM_CE_N=SRAM_UB_N=SRAM_LB_N=0.
REQ-024 Write phases SHALL drive SRAM_WE_N=0, SRAM_OE_N=1, and SRAM_DQ with the captured halfword.
REQ-025 Read phases SHALL drive SRAM_WE_N=1, SRAM_OE_N=0, and leave SRAM_DQ high-Z.
REQ-026 On reads, SRAM_DQ SHALL be sampled into read_data[15:0] on the last LOW cycle and into read_data[31:16] on the last HIGH cycle.
REQ-027 read_data SHALL hold its value until the next read overwrites it; writes SHALL leave it unchanged.
REQ-028 In IDLE and DONE, all SRAM strobes SHALL be 1 and SRAM_DQ high-Z.
REQ-029 Changes to rd_en, wr_en, address or write_data after capture SHALL be ignored until IDLE is re-entered.
REQ-030 A request present in the cycle after DONE SHALL start a new transaction from IDLE.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE, phase counter=0, read_data=0, and all strobes=1 with SRAM_DQ high-Z, including mid-transaction; the aborted access SHALL NOT complete.
REQ-032 ready SHALL follow REQ-018 from the first cycle after reset.

Structure
REQ-033 FSM state enum and SRAM data width constant (16) SHALL reside in the shared arm_pkg.
REQ-034 SHALL be a single module with no sub-module; the phase counter width SHALL be $clog2(PHASE_CYCLES+1).

Verification
REQ-035 Write, PHASE_CYCLES=2: wr_en=1, address=1028, write_data=0xDEADBEEF -> ready=0 for 5 cycles; SRAM_ADDR=2 with DQ=0xBEEF, WE_N=0 for 2 cycles; SRAM_ADDR=3 with DQ=0xDEAD for 2 cycles; ready=1 in cycle 6.
REQ-036 Read-back: rd_en=1, address=1028, SRAM model returns stored data -> read_data=0xDEADBEEF when ready=1; OE_N=0 and DQ undriven by DUT throughout.
REQ-037 Simultaneous: rd_en=wr_en=1, write_data=0x12345678 -> write performed, read_data unchanged.
REQ-038 Reset mid-op: rst=1 in the second HIGH cycle of a write -> next cycle IDLE, strobes=1, read_data=0, and SRAM halfword 3 not written.
REQ-039 Back-to-back and wrap: write at 1024 then immediate read at 1020 -> second access starts the cycle after DONE, with SRAM_ADDR = low SRAM_AW bits of 0x7FFFFFFE/0x7FFFFFFF.
